mem_copy_engine: RTL and testbench

- Initiator-side block that drives the CPU modport of dual_port_ram_if.
- Copies a block of words from a source memory into a destination memory, one word per cycle, using two independent CPU-side connections (read port, write port).
- Sits between the control logic (start/len/addresses) and the MEM-side RAMs; it is the master for both RAM ports.

---
 rtl/mem_copy_pkg.sv | 14 +
 rtl/dual_port_ram_if.sv | 16 +
 rtl/mem_copy_engine.sv | 166 ++++++++++++++++
 tb/tb_mem_copy_engine.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types for the memory copy engine.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_copy_pkg;

    // Copy sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : mem_copy_pkg

// File: rtl/dual_port_ram_if.sv
// One port of a RAM: the CPU side issues accesses, the MEM side answers them.
// Latency: a read issued at an edge returns rdata throughout the next cycle.
// Backpressure: none; the memory accepts one access per cycle unconditionally.
interface dual_port_ram_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport CPU (output en, we, addr, wdata, input rdata);
    modport MEM (input en, we, addr, wdata, output rdata);
endinterface : dual_port_ram_if

// File: rtl/mem_copy_engine.sv
// Copies len words from a source RAM port to a destination RAM port, one word per cycle.
// Latency: reads in cycles 1..N after the accepting edge, writes in 2..N+1, done in N+2.
// Backpressure: none on the RAM side; start is only honoured in IDLE, abort only in READ.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   start/src_addr/dst_addr/len request, captured when start is accepted in IDLE
//   abort                      stops issuing reads; the in-flight write still lands
//   busy                       high while reads/writes are outstanding (READ, DRAIN)
//   done/err/aborted           one-cycle completion pulse with its status flags
//   words_copied               writes issued by the current/last request
//   rd, wr                     CPU-side RAM ports for source and destination
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  words_copied,
    dual_port_ram_if.CPU          rd,
    dual_port_ram_if.CPU          wr
);

    localparam logic [LEN_WIDTH-1:0]  MAX_LEN  = LEN_WIDTH'(DEPTH);
    localparam logic [LEN_WIDTH-1:0]  ONE_LEN  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(1);

    state_t state_q, state_d;

    logic                  accept;     // start taken this cycle
    logic                  len_bad;    // requested length exceeds memory size
    logic                  rd_issue;   // read presented on rd this cycle
    logic                  abort_hit;  // abort cut the read phase short

    logic [ADDR_WIDTH-1:0] rd_addr_q;  // next source address (wraps naturally)
    logic [ADDR_WIDTH-1:0] wr_addr_q;  // next destination address
    logic [LEN_WIDTH-1:0]  remain_q;   // reads still to issue
    logic                  wr_vld_q;   // a read was issued last cycle -> write now
    logic                  err_q;
    logic                  aborted_q;
    logic [LEN_WIDTH-1:0]  wc_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        rd_issue  = 1'b0;
        abort_hit = 1'b0;
        len_bad   = (len > MAX_LEN);

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len_bad || (len == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    // No read this cycle, so nothing is left in flight once the
                    // current write (if any) lands: skip DRAIN.
                    abort_hit = 1'b1;
                    state_d   = DONE;
                end else begin
                    rd_issue = 1'b1;
                    if (remain_q == ONE_LEN) begin
                        state_d = DRAIN;
                    end
                end
            end
            // DRAIN is only entered right after the last read, so exactly one
            // write is pending and it is performed this cycle.
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Address/count datapath and the one-stage write pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            remain_q  <= '0;
            wr_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            wc_q      <= '0;
        end else begin
            wr_vld_q <= rd_issue;
            if (accept) begin
                rd_addr_q <= src_addr;
                wr_addr_q <= dst_addr;
                remain_q  <= len;
                err_q     <= len_bad;
                aborted_q <= 1'b0;
                wc_q      <= '0;
            end else begin
                if (rd_issue) begin
                    rd_addr_q <= rd_addr_q + ONE_ADDR;
                    remain_q  <= remain_q - ONE_LEN;
                end
                if (wr_vld_q) begin
                    wr_addr_q <= wr_addr_q + ONE_ADDR;
                    wc_q      <= wc_q + ONE_LEN;
                end
                if (abort_hit) begin
                    aborted_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd.en    = rd_issue;
    assign rd.we    = 1'b0;
    assign rd.addr  = rd_addr_q;
    assign rd.wdata = {DATA_WIDTH{1'b0}};

    // Read data is forwarded straight into the write port in the cycle it is valid.
    assign wr.en    = wr_vld_q;
    assign wr.we    = wr_vld_q;
    assign wr.addr  = wr_addr_q;
    assign wr.wdata = rd.rdata;

    assign busy         = (state_q == READ) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign err          = err_q;
    assign aborted      = aborted_q;
    assign words_copied = wc_q;

endmodule : mem_copy_engine

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: two RAM models, event monitor, scoreboard.
// Latency: cycle numbers are counted from the edge that accepts start (edge 0).
// Backpressure: n/a (RAM models accept every access).
module tb_mem_copy_engine;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 9;
    localparam logic [DW-1:0] SENT = 32'hDEAD_BEEF;

    typedef struct { int t; logic [AW-1:0] addr; logic [DW-1:0] data; } ev_t;
    typedef struct { int t; logic err; logic ab; logic [LW-1:0] wc; } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort;
    logic [AW-1:0] src_addr, dst_addr;
    logic [LW-1:0] len;
    logic          busy, done, err, aborted;
    logic [LW-1:0] words_copied;

    dual_port_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rd_if ();
    dual_port_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wr_if ();

    mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .abort(abort), .busy(busy),
        .done(done), .err(err), .aborted(aborted),
        .words_copied(words_copied), .rd(rd_if), .wr(wr_if)
    );

    // ---------------- RAM models (1-cycle read latency) ----------------
    logic [DW-1:0] src_mem   [256];
    logic [DW-1:0] dst_mem   [256];
    logic [DW-1:0] src_model [256];
    logic          ld_en = 1'b0;
    logic          clr   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_dat  = '0;

    always @(posedge clk) begin
        if (ld_en) src_mem[ld_addr] <= ld_dat;
        if (rd_if.en && !rd_if.we) rd_if.rdata <= src_mem[rd_if.addr];
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) dst_mem[i] <= SENT;
        end else if (wr_if.en && wr_if.we) begin
            dst_mem[wr_if.addr] <= wr_if.wdata;
        end
        if (wr_if.en && !wr_if.we) wr_if.rdata <= dst_mem[wr_if.addr];
    end

    // ---------------- monitor: records what the DUT does ----------------
    int    cyc = 0;
    int    bad_we = 0;
    ev_t   wr_obs[$], rd_obs[$], exp_wr[$], exp_rd[$];
    done_t done_obs[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_if.en) rd_obs.push_back(ev_t'{t: cyc, addr: rd_if.addr, data: '0});
        if (wr_if.en) wr_obs.push_back(ev_t'{t: cyc, addr: wr_if.addr, data: wr_if.wdata});
        if (done) done_obs.push_back(done_t'{t: cyc, err: err, ab: aborted, wc: words_copied});
        if (rd_if.we !== 1'b0 || rd_if.wdata !== '0 || wr_if.we !== wr_if.en) bad_we <= bad_we + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int s, wbase, rbase, dbase;

    function automatic logic [DW-1:0] pat(input int a);
        return {8'h5A, 8'(a), 8'(a ^ 32'hFF), 8'(a * 3)};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic load(input int a, input logic [DW-1:0] d);
        ld_addr = AW'(a);
        ld_dat  = d;
        ld_en   = 1'b1;
        src_model[AW'(a)] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic clear_dst();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic push_exp(input logic [AW-1:0] sa, input logic [AW-1:0] da,
                            input int n, input int off);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(ev_t'{t: off + i + 1, addr: AW'(sa + i), data: '0});
            exp_wr.push_back(ev_t'{t: off + i + 2, addr: AW'(da + i), data: src_model[AW'(sa + i)]});
        end
    endtask

    // Drives start at a negedge, holds it for 'hold' edges; cycle 1 follows edge 0.
    task automatic launch(input logic [AW-1:0] sa, input logic [AW-1:0] da,
                          input logic [LW-1:0] n, input int npush, input int hold);
        @(negedge clk);
        exp_wr.delete();
        exp_rd.delete();
        src_addr = sa;
        dst_addr = da;
        len      = n;
        start    = 1'b1;
        s        = cyc;
        wbase    = wr_obs.size();
        rbase    = rd_obs.size();
        dbase    = done_obs.size();
        push_exp(sa, da, npush, 0);
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int cnt, input int budget);
        int k = 0;
        while (done_obs.size() < dbase + cnt && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++;
        if ({busy, done, err, aborted} !== 4'b0 || words_copied !== '0)
            $display("FAIL reset_status got busy=%b done=%b err=%b ab=%b wc=%0d want all 0",
                     busy, done, err, aborted, words_copied);
        else n_pass++;
        n_checks++;
        if ({rd_if.en, wr_if.en, wr_if.we} !== 3'b0)
            $display("FAIL reset_enables got rd.en=%b wr.en=%b wr.we=%b want 0", rd_if.en, wr_if.en, wr_if.we);
        else n_pass++;
        n_checks++;
        if (rd_if.addr !== '0 || wr_if.addr !== '0)
            $display("FAIL reset_addr got rd=%h wr=%h want 00", rd_if.addr, wr_if.addr);
        else n_pass++;
    endtask

    task automatic test_basic();
        ev_t e, o; done_t dr; logic b1; int w0, nexp;
        for (int i = 0; i < 4; i++) load(16 + i, 32'hA0 + i);
        clear_dst();
        launch(8'h10, 8'h40, 9'd4, 4, 1);
        b1 = busy;
        wait_done(1, 30);
        n_checks++;
        if (b1 !== 1'b1) $display("FAIL basic_busy got %b want 1", b1); else n_pass++;
        w0 = wbase; nexp = exp_wr.size();
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front(); n_checks++;
            if (wbase < wr_obs.size()) o = wr_obs[wbase]; else o = ev_t'{t: -1, addr: '0, data: '0};
            wbase++;
            if (o.t - s !== e.t || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL basic_write got c%0d a=%h d=%h want c%0d a=%h d=%h", o.t - s, o.addr, o.data, e.t, e.addr, e.data);
            else n_pass++;
        end
        n_checks++;
        if (wr_obs.size() - w0 !== nexp) $display("FAIL basic_write_count got %0d want %0d", wr_obs.size() - w0, nexp); else n_pass++;
        n_checks++;
        if (done_obs.size() - dbase !== 1) $display("FAIL basic_done_pulses got %0d want 1", done_obs.size() - dbase); else n_pass++;
        if (done_obs.size() > dbase) dr = done_obs[dbase]; else dr = done_t'{t: -1, err: 1'bx, ab: 1'bx, wc: 'x};
        n_checks++;
        if (dr.t - s !== 6 || dr.err !== 1'b0 || dr.ab !== 1'b0 || dr.wc !== 9'd4)
            $display("FAIL basic_done got c%0d err=%b ab=%b wc=%0d want c6 err=0 ab=0 wc=4", dr.t - s, dr.err, dr.ab, dr.wc);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dst_mem[8'h40 + i] !== 32'hA0 + i)
                $display("FAIL basic_dst[%0d] got %h want %h", i, dst_mem[8'h40 + i], 32'hA0 + i);
            else n_pass++;
        end
        n_checks++;
        if (dst_mem[8'h44] !== SENT) $display("FAIL basic_dst_past got %h want %h", dst_mem[8'h44], SENT); else n_pass++;
    endtask

    task automatic test_wrap();
        ev_t e, o; done_t dr; int w0, nexp;
        clear_dst();
        launch(8'hFE, 8'hFD, 9'd4, 4, 1);
        wait_done(1, 30);
        nexp = exp_rd.size();
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front(); n_checks++;
            if (rbase < rd_obs.size()) o = rd_obs[rbase]; else o = ev_t'{t: -1, addr: '0, data: '0};
            rbase++;
            if (o.t - s !== e.t || o.addr !== e.addr)
                $display("FAIL wrap_read got c%0d a=%h want c%0d a=%h", o.t - s, o.addr, e.t, e.addr);
            else n_pass++;
        end
        w0 = wbase;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front(); n_checks++;
            if (wbase < wr_obs.size()) o = wr_obs[wbase]; else o = ev_t'{t: -1, addr: '0, data: '0};
            wbase++;
            if (o.t - s !== e.t || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL wrap_write got c%0d a=%h d=%h want c%0d a=%h d=%h", o.t - s, o.addr, o.data, e.t, e.addr, e.data);
            else n_pass++;
        end
        n_checks++;
        if (wr_obs.size() - w0 !== nexp) $display("FAIL wrap_write_count got %0d want %0d", wr_obs.size() - w0, nexp); else n_pass++;
        if (done_obs.size() > dbase) dr = done_obs[dbase]; else dr = done_t'{t: -1, err: 1'bx, ab: 1'bx, wc: 'x};
        n_checks++;
        if (dr.t - s !== 6 || dr.err !== 1'b0 || dr.wc !== 9'd4)
            $display("FAIL wrap_done got c%0d err=%b wc=%0d want c6 err=0 wc=4", dr.t - s, dr.err, dr.wc);
        else n_pass++;
    endtask

    task automatic test_zero_and_err();
        done_t dr; logic b1;
        for (int k = 0; k < 2; k++) begin
            launch(8'h08, 8'h08, (k == 0) ? 9'd0 : 9'd257, 0, 1);
            b1 = busy;
            wait_done(1, 20);
            if (done_obs.size() > dbase) dr = done_obs[dbase]; else dr = done_t'{t: -1, err: 1'bx, ab: 1'bx, wc: 'x};
            n_checks++;
            if (dr.t - s !== 1 || dr.err !== (k == 1) || dr.ab !== 1'b0 || dr.wc !== '0 || b1 !== 1'b0)
                $display("FAIL short_done[%0d] got c%0d err=%b ab=%b wc=%0d busy=%b want c1 err=%0d ab=0 wc=0 busy=0",
                         k, dr.t - s, dr.err, dr.ab, dr.wc, b1, k);
            else n_pass++;
            n_checks++;
            if (rd_obs.size() !== rbase || wr_obs.size() !== wbase || done_obs.size() - dbase !== 1)
                $display("FAIL short_access[%0d] got reads=%0d writes=%0d dones=%0d want 0 0 1",
                         k, rd_obs.size() - rbase, wr_obs.size() - wbase, done_obs.size() - dbase);
            else n_pass++;
        end
    endtask

    task automatic test_full();
        ev_t e, o; done_t dr; int w0, nexp;
        clear_dst();
        launch(8'h00, 8'h00, 9'd256, 256, 1);
        wait_done(1, 400);
        w0 = wbase; nexp = exp_wr.size();
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front(); n_checks++;
            if (wbase < wr_obs.size()) o = wr_obs[wbase]; else o = ev_t'{t: -1, addr: '0, data: '0};
            wbase++;
            if (o.t - s !== e.t || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL full_write got c%0d a=%h d=%h want c%0d a=%h d=%h", o.t - s, o.addr, o.data, e.t, e.addr, e.data);
            else n_pass++;
        end
        n_checks++;
        if (wr_obs.size() - w0 !== nexp) $display("FAIL full_write_count got %0d want %0d", wr_obs.size() - w0, nexp); else n_pass++;
        if (done_obs.size() > dbase) dr = done_obs[dbase]; else dr = done_t'{t: -1, err: 1'bx, ab: 1'bx, wc: 'x};
        n_checks++;
        if (dr.t - s !== 258 || dr.err !== 1'b0 || dr.ab !== 1'b0 || dr.wc !== 9'd256)
            $display("FAIL full_done got c%0d err=%b ab=%b wc=%0d want c258 err=0 ab=0 wc=256", dr.t - s, dr.err, dr.ab, dr.wc);
        else n_pass++;
    endtask

    task automatic test_abort();
        ev_t e, o; done_t dr; int w0, r0, nexp;
        clear_dst();
        launch(8'h20, 8'h60, 9'd16, 4, 1);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done(1, 40);
        r0 = rbase; nexp = exp_rd.size();
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front(); n_checks++;
            if (rbase < rd_obs.size()) o = rd_obs[rbase]; else o = ev_t'{t: -1, addr: '0, data: '0};
            rbase++;
            if (o.t - s !== e.t || o.addr !== e.addr)
                $display("FAIL abort_read got c%0d a=%h want c%0d a=%h", o.t - s, o.addr, e.t, e.addr);
            else n_pass++;
        end
        n_checks++;
        if (rd_obs.size() - r0 !== nexp) $display("FAIL abort_read_count got %0d want %0d", rd_obs.size() - r0, nexp); else n_pass++;
        w0 = wbase; nexp = exp_wr.size();
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front(); n_checks++;
            if (wbase < wr_obs.size()) o = wr_obs[wbase]; else o = ev_t'{t: -1, addr: '0, data: '0};
            wbase++;
            if (o.t - s !== e.t || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL abort_write got c%0d a=%h d=%h want c%0d a=%h d=%h", o.t - s, o.addr, o.data, e.t, e.addr, e.data);
            else n_pass++;
        end
        n_checks++;
        if (wr_obs.size() - w0 !== nexp) $display("FAIL abort_write_count got %0d want %0d", wr_obs.size() - w0, nexp); else n_pass++;
        if (done_obs.size() > dbase) dr = done_obs[dbase]; else dr = done_t'{t: -1, err: 1'bx, ab: 1'bx, wc: 'x};
        n_checks++;
        if (dr.t - s !== 6 || dr.err !== 1'b0 || dr.ab !== 1'b1 || dr.wc !== 9'd4)
            $display("FAIL abort_done got c%0d err=%b ab=%b wc=%0d want c6 err=0 ab=1 wc=4", dr.t - s, dr.err, dr.ab, dr.wc);
        else n_pass++;
        n_checks++;
        if (dst_mem[8'h64] !== SENT) $display("FAIL abort_dst_past got %h want %h", dst_mem[8'h64], SENT); else n_pass++;
    endtask

    task automatic test_back_to_back();
        ev_t e, o; done_t d0, d1; int w0, nexp;
        clear_dst();
        // start held through edge 6: first copy ends in cycle 5, IDLE in cycle 6 re-accepts.
        launch(8'h30, 8'h90, 9'd3, 3, 7);
        push_exp(8'h30, 8'h90, 3, 6);
        wait_done(2, 40);
        w0 = wbase; nexp = exp_wr.size();
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front(); n_checks++;
            if (wbase < wr_obs.size()) o = wr_obs[wbase]; else o = ev_t'{t: -1, addr: '0, data: '0};
            wbase++;
            if (o.t - s !== e.t || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL b2b_write got c%0d a=%h d=%h want c%0d a=%h d=%h", o.t - s, o.addr, o.data, e.t, e.addr, e.data);
            else n_pass++;
        end
        n_checks++;
        if (wr_obs.size() - w0 !== nexp) $display("FAIL b2b_write_count got %0d want %0d", wr_obs.size() - w0, nexp); else n_pass++;
        n_checks++;
        if (done_obs.size() - dbase !== 2) $display("FAIL b2b_done_pulses got %0d want 2", done_obs.size() - dbase); else n_pass++;
        d0 = done_t'{t: -1, err: 1'bx, ab: 1'bx, wc: 'x};
        d1 = d0;
        if (done_obs.size() > dbase)     d0 = done_obs[dbase];
        if (done_obs.size() > dbase + 1) d1 = done_obs[dbase + 1];
        n_checks++;
        if (d0.t - s !== 5 || d1.t - s !== 11 || d0.wc !== 9'd3 || d1.wc !== 9'd3)
            $display("FAIL b2b_done got c%0d/c%0d wc=%0d/%0d want c5/c11 wc=3/3", d0.t - s, d1.t - s, d0.wc, d1.wc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_dst();
        launch(8'h50, 8'hA0, 9'd8, 0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_if.en, wr_if.en, wr_if.we, busy, done} !== 5'b0 || words_copied !== '0 || rd_if.addr !== '0 || wr_if.addr !== '0)
            $display("FAIL midreset_outputs got rd.en=%b wr.en=%b wr.we=%b busy=%b done=%b wc=%0d rda=%h wra=%h want all 0",
                     rd_if.en, wr_if.en, wr_if.we, busy, done, words_copied, rd_if.addr, wr_if.addr);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_obs.size() !== dbase) $display("FAIL midreset_done got %0d pulses want 0", done_obs.size() - dbase); else n_pass++;
        n_checks++;
        if (dst_mem[8'hA0] !== src_model[8'h50] || dst_mem[8'hA1] !== SENT)
            $display("FAIL midreset_dst got %h %h want %h %h", dst_mem[8'hA0], dst_mem[8'hA1], src_model[8'h50], SENT);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        for (int a = 0; a < 256; a++) load(a, pat(a));
        test_basic();
        test_wrap();
        test_zero_and_err();
        test_full();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (bad_we !== 0) $display("FAIL port_static got %0d bad cycles want 0", bad_we); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_copy_engine
